dev_io_filter: RTL
==================

DEV_IO_FILTER -- requirements
Module: dev_io_filter

Interface
REQ-001 Parameter: TIMER_BITS, default 16, width of the timestamp counter and the capture register.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 pin  input  1  raw external I/O pin, asynchronous to clk.
REQ-005 filter_len  input  4  glitch-filter length N, 0..15 cycles.
REQ-006 edge_sel  input  2  capture edge select: 0 none, 1 rising, 2 falling, 3 both.
REQ-007 clear  input  1  one-cycle pulse that acknowledges a capture.
REQ-008 io_level  output  1  filtered, synchronized pin level.
REQ-009 io_risen  output  1  one-cycle pulse on a filtered rising edge; feeds the timer's io_risen.
REQ-010 io_fallen  output  1  one-cycle pulse on a filtered falling edge; feeds the timer's io_fallen.
REQ-011 capture  output  TIMER_BITS  timestamp latched on the selected edge.
REQ-012 int_capture  output  1  capture pending (level).
REQ-013 overrun  output  1  a selected edge occurred while a capture was already pending.

Function
REQ-014 The block SHALL pass pin through a 2-flop synchronizer (sync1 -> sync2) before any other use.
REQ-015 The block SHALL hold a 4-bit filter counter fcnt that clears in any cycle where sync2 == io_level.
REQ-016 When sync2 != io_level and fcnt < filter_len, fcnt SHALL increment.
REQ-017 When sync2 != io_level and fcnt >= filter_len, io_level SHALL take sync2 and fcnt SHALL clear.
REQ-018 The >= compare in REQ-017 SHALL apply so that lowering filter_len mid-count never stalls the filter.
REQ-019 Latency: a pin change stable from before edge k SHALL appear on io_level at edge k+2+N.
  - With N=0, this is edge k+2.
REQ-020 Any pin pulse whose sync2 image is shorter than N+1 cycles SHALL NOT change io_level.
REQ-021 io_risen SHALL be high for exactly the first cycle in which io_level reads 1 after reading 0.
  - io_fallen SHALL behave likewise for the 1 -> 0 transition.
  - io_risen and io_fallen SHALL never be high together.
REQ-022 A free-running TIMER_BITS timestamp counter SHALL increment every clk.
  - It SHALL wrap from all-ones to 0.
REQ-023 A selected edge is io_risen with edge_sel[0]=1, or io_fallen with edge_sel[1]=1.
  - With edge_sel=0, no edge is selected and no capture occurs.
REQ-024 On a selected edge with int_capture=0 or clear=1:
  - capture SHALL load the timestamp value present in that cycle.
  - int_capture SHALL become 1 on the next edge.
REQ-025 On a selected edge with int_capture=1 and clear=0:
  - capture SHALL hold its value.
  - overrun SHALL set.
REQ-026 clear with no selected edge SHALL zero int_capture and overrun on the next edge.
REQ-027 When clear and a selected edge coincide:
  - the event wins: int_capture stays 1 and capture is updated.
  - overrun SHALL be 0.
REQ-028 Changing edge_sel SHALL affect only edges detected after the change; a pending capture is kept.

Reset
REQ-029 reset SHALL force the following to 0 asynchronously, independent of clk:
  - sync1, sync2, fcnt and the timestamp counter.
  - io_level, io_risen, io_fallen.
  - capture, int_capture, overrun.
REQ-030 A reset asserted mid-filter or mid-capture SHALL discard the partial count and any pending capture.
REQ-031 After release with pin=1:
  - the first io_risen SHALL follow per REQ-019.
  - no spurious io_fallen SHALL occur.

Verification
REQ-032 N=0, edge_sel=1, pin 0->1 before edge 10 -> io_level=1 and io_risen=1 at edge 12 only; capture equals the timestamp in that cycle; int_capture=1 at edge 13.
REQ-033 N=3: pin high for 3 sync cycles -> no change on io_level, io_risen or io_fallen; pin high for 4 cycles -> io_level rises at edge k+5.
REQ-034 edge_sel=3, two edges with no clear -> first timestamp retained, overrun=1; then clear -> int_capture=0 and overrun=0 next cycle.
REQ-035 clear coincident with a selected edge -> capture is the new timestamp, int_capture=1, overrun=0.
REQ-036 Timestamp at 0xFFFF (TIMER_BITS=16) -> next cycle 0x0000; a capture in the wrap cycle records 0x0000.
REQ-037 reset pulse asserted between clk edges while fcnt=2 and int_capture=1 -> all outputs read 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/dev_io_filter_if.sv
// Signal bundle for dev_io_filter: raw pin and configuration in,
// filtered level, edge pulses and capture status out.
interface dev_io_filter_if #(
    parameter int TIMER_BITS = 16
);
    logic                  pin;
    logic [3:0]            filter_len;
    logic [1:0]            edge_sel;
    logic                  clear;
    logic                  io_level;
    logic                  io_risen;
    logic                  io_fallen;
    logic [TIMER_BITS-1:0] capture;
    logic                  int_capture;
    logic                  overrun;

    modport master (
        output pin, filter_len, edge_sel, clear,
        input  io_level, io_risen, io_fallen, capture, int_capture, overrun
    );

    modport slave (
        input  pin, filter_len, edge_sel, clear,
        output io_level, io_risen, io_fallen, capture, int_capture, overrun
    );
endinterface

// File: rtl/dev_io_filter.sv
// Pin synchronizer + glitch filter with edge pulses, and a free-running
// timestamp that is captured on selected filtered edges.
module dev_io_filter #(
    parameter int TIMER_BITS = 16
) (
    input  logic            clk,
    input  logic            reset,
    dev_io_filter_if.slave  io
);
    logic                  sync1_q, sync1_d;
    logic                  sync2_q, sync2_d;
    logic [3:0]            fcnt_q, fcnt_d;
    logic                  level_q, level_d;
    logic                  risen_q, risen_d;
    logic                  fallen_q, fallen_d;
    logic [TIMER_BITS-1:0] ts_q, ts_d;
    logic [TIMER_BITS-1:0] capture_q, capture_d;
    logic                  int_cap_q, int_cap_d;
    logic                  overrun_q, overrun_d;
    logic                  sel;

    always_comb begin
        sync1_d = io.pin;
        sync2_d = sync1_q;

        // >= rather than == so a filter_len lowered mid-count still lets the edge through
        fcnt_d  = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (fcnt_q >= io.filter_len) begin
                level_d = sync2_q;
            end else begin
                fcnt_d = fcnt_q + 4'd1;
            end
        end
        risen_d  = level_d & ~level_q;
        fallen_d = ~level_d & level_q;

        ts_d = ts_q + TIMER_BITS'(1);

        sel       = (risen_q & io.edge_sel[0]) | (fallen_q & io.edge_sel[1]);
        capture_d = capture_q;
        int_cap_d = int_cap_q;
        overrun_d = overrun_q;
        // A new event beats a simultaneous clear: it is captured fresh, not flagged as overrun
        if (sel) begin
            if (!int_cap_q || io.clear) begin
                capture_d = ts_q;
                int_cap_d = 1'b1;
                if (io.clear) begin
                    overrun_d = 1'b0;
                end
            end else begin
                overrun_d = 1'b1;
            end
        end else if (io.clear) begin
            int_cap_d = 1'b0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            fcnt_q    <= '0;
            level_q   <= 1'b0;
            risen_q   <= 1'b0;
            fallen_q  <= 1'b0;
            ts_q      <= '0;
            capture_q <= '0;
            int_cap_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            fcnt_q    <= fcnt_d;
            level_q   <= level_d;
            risen_q   <= risen_d;
            fallen_q  <= fallen_d;
            ts_q      <= ts_d;
            capture_q <= capture_d;
            int_cap_q <= int_cap_d;
            overrun_q <= overrun_d;
        end
    end

    assign io.io_level    = level_q;
    assign io.io_risen    = risen_q;
    assign io.io_fallen   = fallen_q;
    assign io.capture     = capture_q;
    assign io.int_capture = int_cap_q;
    assign io.overrun     = overrun_q;
endmodule
